random_delay: RTL and testbench

RANDOM_DELAY -- requirements
Module: random_delay

---
 rtl/random_delay.sv | 105 ++++++++++
 tb/tb_random_delay.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/random_delay.sv
// Random delay timer: loads a pseudo-random count on trigger and pulses time_out after that many ticks.
// Latency: busy rises the cycle after an accepted trigger; time_out rises the cycle after the N-th tick.
// Backpressure: none; triggers outside IDLE are dropped. Optional abort port under RANDOM_DELAY_ABORT_EN.
module random_delay #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             tick,
  input  logic [WIDTH-1:0] rnd,
`ifdef RANDOM_DELAY_ABORT_EN
  input  logic             abort,
`endif
  output logic             lfsr_en,
  output logic             busy,
  output logic             time_out,
  output logic [WIDTH-1:0] delay_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] delay_d;
  logic             lfsr_en_q;
  logic             time_out_q;
  logic             abort_req;

`ifdef RANDOM_DELAY_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Next-state, counter and captured-delay logic; a zero random value is promoted to 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          cnt_d   = (rnd == '0) ? WIDTH'(1) : rnd;
          delay_d = (rnd == '0) ? WIDTH'(1) : rnd;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (abort_req) begin
          // Abort wins over a concurrent expiring tick
          cnt_d   = '0;
          state_d = IDLE;
        end else if (tick) begin
          if (cnt_q <= WIDTH'(1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and delay registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
    end
  end

  // Registered strobes: lfsr_en stays low in reset and only rises on the first edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_en_q  <= 1'b0;
      time_out_q <= 1'b0;
    end else begin
      lfsr_en_q  <= (state_d == IDLE);
      time_out_q <= (state_d == DONE);
    end
  end

  assign lfsr_en  = lfsr_en_q;
  assign time_out = time_out_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_random_delay.sv
// Self-checking bench for random_delay: directed steps with a reference model and a delay scoreboard.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
// Build with RANDOM_DELAY_ABORT_EN defined to also exercise the abort port.
module tb_random_delay;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         trigger = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] rnd = '0;
`ifdef RANDOM_DELAY_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         lfsr_en;
  logic         busy;
  logic         time_out;
  logic [W-1:0] delay_q;

  int checks = 0;
  int errors = 0;

  // Reference model state: 0 idle, 1 counting, 2 done
  int           m_st = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_dq = '0;
  logic [W-1:0] sb_q[$];

  always #5 clk = ~clk;

  random_delay #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .trigger  (trigger),
    .tick     (tick),
    .rnd      (rnd),
`ifdef RANDOM_DELAY_ABORT_EN
    .abort    (abort),
`endif
    .lfsr_en  (lfsr_en),
    .busy     (busy),
    .time_out (time_out),
    .delay_q  (delay_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_busy"},    32'(busy),     32'(m_st != 0));
    chk({tag, "_timeout"}, 32'(time_out), 32'(m_st == 2));
    chk({tag, "_lfsr_en"}, 32'(lfsr_en),  32'(m_st == 0));
    chk({tag, "_delay_q"}, 32'(delay_q),  32'(m_dq));
  endtask

  task automatic step(input string tag, input logic tg, input logic tk,
                      input logic [W-1:0] r, input logic ab);
    logic [W-1:0] exp_d;
    trigger = tg;
    tick    = tk;
    rnd     = r;
`ifdef RANDOM_DELAY_ABORT_EN
    abort   = ab;
`endif
    case (m_st)
      0: if (tg) begin
        m_cnt = (r == 0) ? 1 : int'(r);
        m_dq  = W'(m_cnt);
        m_st  = 1;
        sb_q.push_back(m_dq);
      end
      1: begin
`ifdef RANDOM_DELAY_ABORT_EN
        if (ab) begin
          m_st = 0;
          void'(sb_q.pop_back());
        end else
`endif
        if (tk) begin
          m_cnt--;
          if (m_cnt == 0) m_st = 2;
        end
      end
      default: m_st = 0;
    endcase
    @(posedge clk);
    #1;
    check_outputs(tag);
    if (time_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        exp_d = sb_q.pop_front();
        chk({tag, "_sb_delay"}, 32'(delay_q), 32'(exp_d));
      end
    end
    if (ab) begin end
  endtask

  task automatic reset_now(input string tag);
    #2 rst = 1'b0;
    #1;
    m_st = 0; m_cnt = 0; m_dq = '0;
    sb_q.delete();
    chk({tag, "_busy"},    32'(busy),     32'd0);
    chk({tag, "_timeout"}, 32'(time_out), 32'd0);
    chk({tag, "_lfsr_en"}, 32'(lfsr_en),  32'd0);
    chk({tag, "_delay_q"}, 32'(delay_q),  32'd0);
    #2 rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_timeout", 32'(time_out), 32'd0);
    chk("rst_lfsr_en", 32'(lfsr_en),  32'd0);
    chk("rst_delay_q", 32'(delay_q),  32'd0);
    #4 rst = 1'b1;
    step("idle", 1'b0, 1'b0, W'(17), 1'b0);
    step("idle2", 1'b0, 1'b1, W'(33), 1'b0);

    // rnd=5, tick every 4th cycle
    step("r5_trig", 1'b1, 1'b0, W'(5), 1'b0);
    for (int i = 0; i < 23; i++) step("r5", 1'b0, (i % 4) == 3, W'(i), 1'b0);

    // rnd=0 -> zero guard loads 1
    step("r0_trig", 1'b1, 1'b0, W'(0), 1'b0);
    for (int i = 0; i < 6; i++) step("r0", 1'b0, (i % 2) == 1, W'(0), 1'b0);

    // Tick coincident with trigger is ignored
    step("r3_trig", 1'b1, 1'b1, W'(3), 1'b0);
    for (int i = 0; i < 9; i++) step("r3", 1'b0, (i % 2) == 0, W'(3), 1'b0);

    // Triggers while busy with a different rnd are ignored
    step("r4_trig", 1'b1, 1'b0, W'(4), 1'b0);
    for (int i = 0; i < 12; i++) step("r4_retrig", (i % 3) == 0, (i % 3) == 1, W'(9), 1'b0);
    step("r4_tail", 1'b0, 1'b0, W'(9), 1'b0);

    // Trigger held high restarts right after DONE
    for (int i = 0; i < 12; i++) step("held", 1'b1, 1'b1, W'(2), 1'b0);
    step("held_end", 1'b0, 1'b0, W'(0), 1'b0);
    step("held_end2", 1'b0, 1'b0, W'(0), 1'b0);

    // Reset in COUNT with counter=2: no time_out afterwards, lfsr_en back after release
    step("rs_trig", 1'b1, 1'b0, W'(6), 1'b0);
    for (int i = 0; i < 4; i++) step("rs_cnt", 1'b0, 1'b1, W'(6), 1'b0);
    reset_now("rs_mid");
    for (int i = 0; i < 5; i++) step("rs_after", 1'b0, 1'b1, W'(6), 1'b0);

    // Wide value near the top of the range
    step("big_trig", 1'b1, 1'b0, W'(127), 1'b0);
    for (int i = 0; i < 129; i++) step("big", 1'b0, 1'b1, W'(1), 1'b0);

`ifdef RANDOM_DELAY_ABORT_EN
    // Abort together with the final tick wins; abort in IDLE ignored
    step("ab_trig", 1'b1, 1'b0, W'(2), 1'b0);
    step("ab_tick", 1'b0, 1'b1, W'(2), 1'b0);
    step("ab_last", 1'b0, 1'b1, W'(2), 1'b1);
    step("ab_idle", 1'b1, 1'b0, W'(3), 1'b1);
    for (int i = 0; i < 5; i++) step("ab_run", 1'b0, 1'b1, W'(3), 1'b1 && (i == 3));
    step("ab_tail", 1'b0, 1'b0, W'(3), 1'b0);
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
